// File: rtl/hbmc_rst_pkg.sv
// Shared definitions for the HyperBus reset sequencer: FSM encodings, counter width, helpers.
package hbmc_rst_pkg;

    typedef enum logic [1:0] {
        ST_DEV_RST   = 2'd0,
        ST_DEV_WAIT  = 2'd1,
        ST_STAGE_REL = 2'd2,
        ST_RUN       = 2'd3
    } hbmc_rst_state_t;

    localparam int RST_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hbmc_rst_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, and it never wraps.
module hbmc_rst_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/hbmc_rst_seq.sv
// HyperBus reset sequencer: device reset pulse, recovery wait, staggered stage releases.
// Optional completed-sequence counter enabled by defining HBMC_RST_SEQ_CNT_EN.
//
// state        | meaning
// ST_DEV_RST   | hb_rstn and all stage resets held low for C_RST_PULSE_CYCLES
// ST_DEV_WAIT  | device out of reset, waiting C_RST_WAIT_CYCLES before stages
// ST_STAGE_REL | stages released one at a time, C_STAGE_GAP apart, bit 0 first
// ST_RUN       | everything released; srst_req restarts the sequence
module hbmc_rst_seq
    import hbmc_rst_pkg::*;
#(
    parameter int C_RST_PULSE_CYCLES = 20,
    parameter int C_RST_WAIT_CYCLES  = 40,
    parameter int C_STAGES           = 3,
    parameter int C_STAGE_GAP        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 srst_req,
    output logic                 hb_rstn,
    output logic [C_STAGES-1:0]  stage_rstn,
    output logic                 busy,
    output logic                 done,
    output logic [RST_CNT_W-1:0] rst_cnt
);

    if ((C_RST_PULSE_CYCLES < 1) || (C_RST_WAIT_CYCLES < 1) || (C_STAGE_GAP < 1) ||
        (C_STAGES < 1) || (C_STAGES > 8)) begin : g_param_err
        $error("hbmc_rst_seq: illegal parameter value");
    end

    localparam int TW = $clog2(max3(C_RST_PULSE_CYCLES, C_RST_WAIT_CYCLES, C_STAGE_GAP)) + 1;
    localparam logic [TW-1:0]       LD_P    = TW'(C_RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0]       LD_W    = TW'(C_RST_WAIT_CYCLES - 1);
    localparam logic [TW-1:0]       LD_G    = TW'(C_STAGE_GAP - 1);
    localparam logic [C_STAGES-1:0] STG_ONE = C_STAGES'(1);

    hbmc_rst_state_t state;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_tc;
    logic            last_rel;

    // Stage resets form a thermometer, so the top bit marks the final release.
    assign last_rel = stage_rstn[C_STAGES-1];

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (rst) begin
            tmr_load = 1'b1;
            tmr_val  = LD_P;
        end else begin
            case (state)
                ST_DEV_RST: if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_W;
                end
                ST_DEV_WAIT: if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_G;
                end
                ST_STAGE_REL: if (last_rel) begin
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end else if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_G;
                end
                ST_RUN: if (srst_req) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_P;
                end
                default: ;
            endcase
        end
    end

    hbmc_rst_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_DEV_RST;
            hb_rstn    <= 1'b0;
            stage_rstn <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_DEV_RST: if (tmr_tc) begin
                    state   <= ST_DEV_WAIT;
                    hb_rstn <= 1'b1;
                end
                ST_DEV_WAIT: if (tmr_tc) begin
                    state      <= ST_STAGE_REL;
                    stage_rstn <= STG_ONE;
                end
                ST_STAGE_REL: if (last_rel) begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (tmr_tc) begin
                    stage_rstn <= (stage_rstn << 1) | STG_ONE;
                end
                ST_RUN: if (srst_req) begin
                    state      <= ST_DEV_RST;
                    hb_rstn    <= 1'b0;
                    stage_rstn <= '0;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                end
                default: state <= ST_DEV_RST;
            endcase
        end
    end

`ifdef HBMC_RST_SEQ_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt <= '0;
        end else if ((state == ST_STAGE_REL) && last_rel && (rst_cnt != '1)) begin
            rst_cnt <= rst_cnt + RST_CNT_W'(1);
        end
    end
`else
    assign rst_cnt = '0;
`endif

endmodule

// File: tb/tb_hbmc_rst_seq.sv
// Self-checking bench for hbmc_rst_seq: default instance plus a minimal P=W=G=S=1 instance.
module tb_hbmc_rst_seq;

`ifdef HBMC_RST_SEQ_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int PA = 20, WA = 40, SA = 3, GA = 4;
    localparam int DA = PA + WA + GA * (SA - 1) + 1;
    localparam int PB = 1, WB = 1, SB = 1, GB = 1;
    localparam int DB = PB + WB + GB * (SB - 1) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       srst_req;
    logic       hb_a, busy_a, done_a, hb_b, busy_b, done_b;
    logic [2:0] stg_a;
    logic [0:0] stg_b;
    logic [7:0] cnt_a, cnt_b;

    int n_tot = 0, n_pass = 0, cyc = 0;
    int ta = 0, ca = 0, tb = 0, cb = 0;

    always #5 clk = ~clk;

    hbmc_rst_seq u_a (
        .clk(clk), .rst(rst), .srst_req(srst_req), .hb_rstn(hb_a),
        .stage_rstn(stg_a), .busy(busy_a), .done(done_a), .rst_cnt(cnt_a)
    );

    hbmc_rst_seq #(
        .C_RST_PULSE_CYCLES(PB), .C_RST_WAIT_CYCLES(WB), .C_STAGES(SB), .C_STAGE_GAP(GB)
    ) u_b (
        .clk(clk), .rst(rst), .srst_req(srst_req), .hb_rstn(hb_b),
        .stage_rstn(stg_b), .busy(busy_b), .done(done_b), .rst_cnt(cnt_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    endtask

    // Expected outputs from elapsed time t since the sequence started.
    function automatic logic [31:0] ref_vec(input int t, input int p, input int w,
                                            input int g, input int s, input int cnt);
        logic [31:0] v;
        int d;
        v = '0;
        d = p + w + g * (s - 1) + 1;
        v[31] = (t >= p);
        for (int k = 0; k < s; k++) v[16 + k] = (t >= p + w + g * k);
        v[9] = !(t >= d);
        v[8] = (t >= d);
        v[7:0] = cnt[7:0];
        return v;
    endfunction

    task automatic adv(input int t_in, input int c_in, input int d,
                       output int t_out, output int c_out);
        t_out = t_in;
        c_out = c_in;
        if (rst) begin
            t_out = 0;
            c_out = 0;
        end else if (t_in >= d && srst_req) begin
            t_out = 0;
        end else if (t_in < d) begin
            t_out = t_in + 1;
            if (t_out == d && CNT_EN && c_out < 255) c_out = c_out + 1;
        end
    endtask

    function automatic logic [31:0] act_a();
        return {hb_a, 7'b0, 5'b0, stg_a, 6'b0, busy_a, done_a, cnt_a};
    endfunction

    function automatic logic [31:0] act_b();
        return {hb_b, 7'b0, 7'b0, stg_b, 6'b0, busy_b, done_b, cnt_b};
    endfunction

    task automatic tick();
        adv(ta, ca, DA, ta, ca);
        adv(tb, cb, DB, tb, cb);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("model_a", act_a(), ref_vec(ta, PA, WA, GA, SA, ca));
        chk("model_b", act_b(), ref_vec(tb, PB, WB, GB, SB, cb));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        for (int i = 0; i < 100000 && cyc < c; i++) tick();
    endtask

    typedef struct {
        int         c;
        logic       hb;
        logic [2:0] stg;
        logic       dn;
    } vec_t;

    vec_t tbl[11];
    int   n_done;

    initial begin
        tbl[0]  = '{0,   1'b0, 3'b000, 1'b0};
        tbl[1]  = '{19,  1'b0, 3'b000, 1'b0};
        tbl[2]  = '{20,  1'b1, 3'b000, 1'b0};
        tbl[3]  = '{59,  1'b1, 3'b000, 1'b0};
        tbl[4]  = '{60,  1'b1, 3'b001, 1'b0};
        tbl[5]  = '{63,  1'b1, 3'b001, 1'b0};
        tbl[6]  = '{64,  1'b1, 3'b011, 1'b0};
        tbl[7]  = '{67,  1'b1, 3'b011, 1'b0};
        tbl[8]  = '{68,  1'b1, 3'b111, 1'b0};
        tbl[9]  = '{69,  1'b1, 3'b111, 1'b1};
        tbl[10] = '{100, 1'b1, 3'b111, 1'b1};

        rst = 1'b1;
        srst_req = 1'b0;
        @(negedge clk);
        do_reset(5);
        chk("reset_state", {hb_a, stg_a, busy_a, done_a, cnt_a}, {1'b0, 3'b000, 1'b1, 1'b0, 8'd0});

        // Nominal timeline with default timing.
        foreach (tbl[i]) begin
            run_to(tbl[i].c);
            chk("timeline", {hb_a, stg_a, done_a, busy_a},
                {tbl[i].hb, tbl[i].stg, tbl[i].dn, ~tbl[i].dn});
        end

        // Soft reset pulse while running.
        srst_req = 1'b1;
        tick();
        srst_req = 1'b0;
        chk("srst_restart", {hb_a, stg_a, done_a, busy_a}, {1'b0, 3'b000, 1'b0, 1'b1});
        run_to(169);
        chk("srst_done_169", {31'b0, done_a}, 32'd0);
        tick();
        chk("srst_done_170", {31'b0, done_a}, 32'd1);

        // Soft reset during the wait phase is ignored; small instance timeline.
        do_reset(3);
        chk("small_c0", {hb_b, stg_b, done_b}, 3'b000);
        for (int i = 0; i < 69; i++) begin
            srst_req = (cyc >= 30 && cyc <= 50);
            tick();
            if (cyc == 1) chk("small_c1", {hb_b, stg_b, done_b}, 3'b100);
            if (cyc == 2) chk("small_c2", {hb_b, stg_b, done_b}, 3'b110);
            if (cyc == 3) chk("small_c3", {hb_b, stg_b, done_b}, 3'b111);
            if (cyc == 60) chk("ign_stage_60", {29'b0, stg_a}, 32'b001);
            if (cyc == 68) chk("ign_done_68", {31'b0, done_a}, 32'd0);
        end
        srst_req = 1'b0;
        chk("ign_done_69", {31'b0, done_a}, 32'd1);

        // Hard reset mid stage-release.
        do_reset(2);
        run_to(62);
        chk("pre_rst_62", {29'b0, stg_a}, 32'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", {hb_a, stg_a, busy_a, done_a, cnt_a}, {1'b0, 3'b000, 1'b1, 1'b0, 8'd0});
        run_to(63 + 68);
        chk("mid_rst_68", {31'b0, done_a}, 32'd0);
        tick();
        chk("mid_rst_69", {31'b0, done_a}, 32'd1);

        // Continuous soft reset: one done cycle per 70-cycle pass.
        do_reset(2);
        srst_req = 1'b1;
        n_done = (done_a === 1'b1) ? 1 : 0;
        for (int i = 0; i < 209; i++) begin
            tick();
            if (done_a === 1'b1) n_done++;
        end
        chk("cont_done_pulses", n_done, 32'd3);
`ifdef HBMC_RST_SEQ_CNT_EN
        chk("cont_cnt_3", {24'b0, cnt_a}, 32'd3);
        run_to(256 * 70 + 10);
        chk("cnt_saturate", {24'b0, cnt_a}, 32'd255);
`else
        chk("cnt_absent", {24'b0, cnt_a}, 32'd0);
`endif
        srst_req = 1'b0;

        // Random stimulus against the reference model.
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (i % 500 < 250) srst_req = ($urandom_range(0, 9) == 0);
            else               srst_req = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        srst_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/hbmc_rst_seq.md
HBMC_RST_SEQ -- requirements
Module: hbmc_rst_seq

Interface
REQ-001 SHALL have parameter C_RST_PULSE_CYCLES, default 20: cycles hb_rstn is held low (device tRP).
REQ-002 SHALL have parameter C_RST_WAIT_CYCLES, default 40: cycles from hb_rstn release to first stage release (device tRPH).
REQ-003 SHALL have parameter C_STAGES, default 3: number of downstream reset outputs, legal range 1..8.
REQ-004 SHALL have parameter C_STAGE_GAP, default 4: cycles between consecutive stage releases.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port srst_req, input, 1: soft-reset request, level-sampled.
REQ-008 SHALL have port hb_rstn, output, 1: HyperBus device reset, active-low.
REQ-009 SHALL have port stage_rstn, output, C_STAGES: per-stage active-low resets; bit 0 is released first.
REQ-010 SHALL have port busy, output, 1: sequence in progress.
REQ-011 SHALL have port done, output, 1: all resets released.
REQ-012 SHALL have port rst_cnt, output, 8: count of completed sequences.

Function
REQ-013 SHALL implement FSM states ST_DEV_RST, ST_DEV_WAIT, ST_STAGE_REL and ST_RUN; all outputs SHALL be registered.
REQ-014 ST_DEV_RST SHALL hold hb_rstn=0 and stage_rstn=0 for exactly C_RST_PULSE_CYCLES cycles, then go to ST_DEV_WAIT with hb_rstn=1.
REQ-015 ST_DEV_WAIT SHALL last exactly C_RST_WAIT_CYCLES cycles, then go to ST_STAGE_REL.
REQ-016 In ST_STAGE_REL, stage_rstn[0] SHALL rise on the first cycle and stage_rstn[k] exactly C_STAGE_GAP*k cycles later; a released bit SHALL stay 1 until the next sequence.
REQ-017 The cycle after stage_rstn[C_STAGES-1] rises, the FSM SHALL enter ST_RUN with busy=0 and done=1.
REQ-018 With cycle 0 being the first cycle after rst deasserts, stage k SHALL rise at P+W+G*k and done at P+W+G*(C_STAGES-1)+1 (P, W, G being the three timing parameters).
REQ-019 srst_req=1 sampled in ST_RUN SHALL cause ST_DEV_RST on the next cycle: hb_rstn=0, stage_rstn=0, done=0 and busy=1 together, with the full sequence restarting.
REQ-020 srst_req SHALL be ignored in every state other than ST_RUN; no request SHALL be queued.
REQ-021 srst_req held high continuously SHALL restart the sequence once per pass through ST_RUN, with ST_RUN lasting one cycle each pass.
REQ-022 busy SHALL equal NOT done at all times.
REQ-023 Timer width SHALL be clog2 of the largest of P, W and G, plus 1; the timer SHALL reload on every state entry and SHALL never wrap.

Reset
REQ-024 rst=1 SHALL force on the next edge: ST_DEV_RST, hb_rstn=0, stage_rstn all 0, busy=1, done=0, timer reloaded, rst_cnt=0.
REQ-025 rst SHALL have priority over srst_req and over any in-progress sequence; rst mid-sequence SHALL restart the sequence from ST_DEV_RST.

Configuration
REQ-026 Macro HBMC_RST_SEQ_CNT_EN defined: rst_cnt SHALL increment by 1 on each entry to ST_RUN and saturate at 255.
REQ-027 Macro HBMC_RST_SEQ_CNT_EN undefined: rst_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Structure
REQ-028 FSM state encodings and the 8-bit rst_cnt width constant SHALL reside in shared package hbmc_rst_pkg.
REQ-029 The timer SHALL be a sub-module hbmc_rst_timer: a loadable down-counter with a terminal-count flag.
REQ-030 Illegal parameter values (any timing parameter below 1, or C_STAGES outside 1..8) SHALL cause an elaboration-time error.

Verification
REQ-031 Defaults; rst high 5 cycles then low -> hb_rstn rises at cycle 20, stage_rstn = 001/011/111 at cycles 60/64/68, done=1 at 69.
REQ-032 srst_req 1-cycle pulse at cycle 100 (in ST_RUN) -> at 101 hb_rstn=0, stage_rstn=000, done=0; done=1 again at 170.
REQ-033 srst_req high during cycles 30..50 (in ST_DEV_WAIT) -> ignored; timing identical to REQ-031.
REQ-034 rst asserted at cycle 62 (stage0 already released) -> next edge all outputs at reset values; after rst drops, full 69-cycle sequence repeats.
REQ-035 srst_req held high, CNT_EN defined -> done pulses 1 cycle every 70 cycles; rst_cnt increments each pass and saturates at 255 after 255 passes.
REQ-036 C_STAGES=1, C_STAGE_GAP=1, P=W=1 -> hb_rstn rises at cycle 1, stage_rstn rises at 2, done=1 at 3.
